// File: rtl/xyz_serial_tx.sv
// Serialises valid/ready words MSB-first onto the x/y/z bundle (x=strobe, z=data, y=receiver ready).
// Optional even-parity trailer bit when XYZ_TX_PARITY_EN is defined.
module xyz_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              p_x,
  input  logic              p_y,
  output logic              p_z,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef XYZ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;      // bits still to send after the one on p_z
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              par, par_nxt;
  logic              p_x_nxt, p_z_nxt, busy_nxt, done_nxt;
  logic              frame_end;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      par     <= 1'b0;
      p_x     <= 1'b0;
      p_z     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      par     <= par_nxt;
      p_x     <= p_x_nxt;
      p_z     <= p_z_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    gap_cnt_nxt = gap_cnt;
    par_nxt     = par;
    p_x_nxt     = p_x;
    p_z_nxt     = p_z;
    done_nxt    = 1'b0;
    frame_end   = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SEND;
          sr_nxt    = {in_data[DATA_W-2:0], 1'b0};
          cnt_nxt   = CNT_LOAD;
          par_nxt   = ^in_data;
          p_x_nxt   = 1'b1;
          p_z_nxt   = in_data[DATA_W-1];
        end
      end
      SEND: begin
        if (p_y) begin
          if (cnt == '0) begin
`ifdef XYZ_TX_PARITY_EN
            state_nxt = PAR;
            p_z_nxt   = par;
`else
            frame_end = 1'b1;
`endif
          end else begin
            p_z_nxt = sr[DATA_W-1];
            sr_nxt  = {sr[DATA_W-2:0], 1'b0};
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
`ifdef XYZ_TX_PARITY_EN
      PAR: frame_end = p_y;
`endif
      GAP: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase

    if (frame_end) begin
      done_nxt = 1'b1;
      p_x_nxt  = 1'b0;
      p_z_nxt  = 1'b0;
      if (GAP_CYCLES > 0) begin
        state_nxt   = GAP;
        gap_cnt_nxt = GAP_LOAD;
      end else begin
        state_nxt = IDLE;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_xyz_serial_tx.sv
// Directed bench for xyz_serial_tx: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0.
module tb_xyz_serial_tx;

  localparam int DW = 8;
`ifdef XYZ_TX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          p_y = 1'b1;
  logic [DW-1:0] in_data = '0;

  logic g1_in_ready, g1_p_x, g1_p_z, g1_busy, g1_done;
  logic g0_in_ready, g0_p_x, g0_p_z, g0_busy, g0_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xyz_serial_tx #(.DATA_W(DW), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g1_in_ready),
    .in_data(in_data), .p_x(g1_p_x), .p_y(p_y), .p_z(g1_p_z),
    .busy(g1_busy), .done(g1_done)
  );

  xyz_serial_tx #(.DATA_W(DW), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g0_in_ready),
    .in_data(in_data), .p_x(g0_p_x), .p_y(p_y), .p_z(g0_p_z),
    .busy(g0_busy), .done(g0_done)
  );

  // Expected serial bit i of a frame: data MSB-first, then even parity if enabled.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[DW-1-i];
    return ^w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    p_y      = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({g1_p_x, g1_p_z, g1_busy, g1_done, g1_in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_idle_g1 cycle %0d: got x,z,busy,done,rdy=%b want 00001", c,
                 {g1_p_x, g1_p_z, g1_busy, g1_done, g1_in_ready});
      end
      checks++;
      if ({g0_p_x, g0_p_z, g0_busy, g0_done, g0_in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_idle_g0 cycle %0d: got x,z,busy,done,rdy=%b want 00001", c,
                 {g0_p_x, g0_p_z, g0_busy, g0_done, g0_in_ready});
      end
      tick();
    end
  endtask

  task automatic test_basic;
    logic [DW-1:0] w;
    w = 8'hA5;
    do_reset();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (g1_p_x !== 1'b1 || g1_p_z !== exp_bit(w, i) || g1_in_ready !== 1'b0 || g1_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit %0d: got x=%b z=%b rdy=%b done=%b want x=1 z=%b rdy=0 done=0",
                 i, g1_p_x, g1_p_z, g1_in_ready, g1_done, exp_bit(w, i));
      end
      tick();
    end
    checks++;
    if (g1_done !== 1'b1 || g1_p_x !== 1'b0 || g1_p_z !== 1'b0 || g1_in_ready !== 1'b0 || g1_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_gap: got done=%b x=%b z=%b rdy=%b busy=%b want 1 0 0 0 1",
               g1_done, g1_p_x, g1_p_z, g1_in_ready, g1_busy);
    end
    tick();
    checks++;
    if (g1_done !== 1'b0 || g1_in_ready !== 1'b1 || g1_busy !== 1'b0 || g1_p_x !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_return: got done=%b rdy=%b busy=%b x=%b want 0 1 0 0",
               g1_done, g1_in_ready, g1_busy, g1_p_x);
    end
  endtask

  task automatic test_stall;
    logic [DW-1:0] w;
    int px_cycles, dones, stall;
    w = 8'h3C;
    px_cycles = 0;
    dones = 0;
    do_reset();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      stall = (i == 1 || i == 4) ? 3 : 0;
      for (int k = 0; k <= stall; k++) begin
        p_y = (k < stall) ? 1'b0 : 1'b1;
        checks++;
        if (g1_p_x !== 1'b1 || g1_p_z !== exp_bit(w, i)) begin
          errors++;
          $display("FAIL stall_bit %0d sub %0d: got x=%b z=%b want x=1 z=%b",
                   i, k, g1_p_x, g1_p_z, exp_bit(w, i));
        end
        px_cycles += int'(g1_p_x);
        dones += int'(g1_done);
        tick();
      end
    end
    p_y = 1'b1;
    for (int c = 0; c < 3; c++) begin
      px_cycles += int'(g1_p_x);
      dones += int'(g1_done);
      tick();
    end
    checks++;
    if (px_cycles != 14 + NB - DW) begin
      errors++;
      $display("FAIL stall_frame_len: got %0d cycles want %0d", px_cycles, 14 + NB - DW);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL stall_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (g0_p_x !== 1'b1 || g0_p_z !== exp_bit(8'hFF, i) || g0_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first_bit %0d: got x=%b z=%b rdy=%b want x=1 z=%b rdy=0",
                 i, g0_p_x, g0_p_z, g0_in_ready, exp_bit(8'hFF, i));
      end
      tick();
    end
    checks++;
    if (g0_done !== 1'b1 || g0_p_x !== 1'b0 || g0_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_between: got done=%b x=%b rdy=%b want 1 0 1", g0_done, g0_p_x, g0_in_ready);
    end
    tick();
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (g0_p_x !== 1'b1 || g0_p_z !== exp_bit(8'h00, i) || g0_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second_bit %0d: got x=%b z=%b done=%b want x=1 z=%b done=0",
                 i, g0_p_x, g0_p_z, g0_done, exp_bit(8'h00, i));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (g0_done !== 1'b1 || g0_p_x !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: got done=%b x=%b want 1 0", g0_done, g0_p_x);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] w;
    w = 8'h81;
    do_reset();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g1_p_x !== 1'b1 || g1_p_z !== exp_bit(w, i)) begin
        errors++;
        $display("FAIL midrst_pre_bit %0d: got x=%b z=%b want x=1 z=%b", i, g1_p_x, g1_p_z, exp_bit(w, i));
      end
      if (i < 3) tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (g1_p_x !== 1'b0 || g1_done !== 1'b0 || g1_in_ready !== 1'b1 || g1_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abandon: got x=%b done=%b rdy=%b busy=%b want 0 0 1 0",
               g1_p_x, g1_done, g1_in_ready, g1_busy);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (g1_p_x !== 1'b1 || g1_p_z !== exp_bit(w, i) || g1_done !== 1'b0) begin
        errors++;
        $display("FAIL midrst_resend_bit %0d: got x=%b z=%b done=%b want x=1 z=%b done=0",
                 i, g1_p_x, g1_p_z, g1_done, exp_bit(w, i));
      end
      tick();
    end
    checks++;
    if (g1_done !== 1'b1 || g1_p_x !== 1'b0) begin
      errors++;
      $display("FAIL midrst_resend_done: got done=%b x=%b want 1 0", g1_done, g1_p_x);
    end
  endtask

  task automatic test_parity;
    logic [DW-1:0] w;
    w = 8'h07;
    do_reset();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (g1_p_x !== 1'b1 || g1_p_z !== exp_bit(w, i) || g1_done !== 1'b0) begin
        errors++;
        $display("FAIL parity_bit %0d: got x=%b z=%b done=%b want x=1 z=%b done=0",
                 i, g1_p_x, g1_p_z, g1_done, exp_bit(w, i));
      end
      tick();
    end
    checks++;
    if (g1_done !== 1'b1 || g1_p_x !== 1'b0 || g1_p_z !== 1'b0) begin
      errors++;
      $display("FAIL parity_done: got done=%b x=%b z=%b want 1 0 0", g1_done, g1_p_x, g1_p_z);
    end
    tick();
    checks++;
    if (g1_done !== 1'b0) begin
      errors++;
      $display("FAIL parity_done_pulse: got done=%b want 0", g1_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xyz_serial_tx.md
Name: xyz_serial_tx

Overview:
- Transmit end of the three-wire x/y/z bundle; the sampling end reads z and drives y.
- Accepts parallel words on a valid/ready port and serialises them MSB-first.
- Outputs: x (frame strobe), z (data bit). Input: y (back-pressure ready from the receiver).
- Sits in the producer module next to the bundle's producer modport, replacing static x/y/z drives with a real protocol.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..32.
- GAP_CYCLES, 1, idle cycles forced with x=0 between frames; legal range 0..15.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  parallel word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  parallel word.
- p_x  output  1  frame strobe; high while a bit is offered on p_z.
- p_y  input  1  receiver ready; a bit transfers on an edge where p_x=1 and p_y=1.
- p_z  output  1  serial data bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last bit of a frame transfers.

Behaviour:
- Reset, sampled on an edge with rst_n=0:
  - state=IDLE; p_x=0, p_z=0, done=0, busy=0.
  - Shift register and counter cleared.
  - in_ready is 1 from the first cycle after reset.
- Reset mid-frame: the frame is abandoned. p_x=0 on the next cycle; no done pulse. Partial frames are never resumed.
- All outputs are registered except in_ready, which is defined as (state==IDLE).
- FSM states: IDLE, SEND, GAP (plus PAR with the optional feature).
- IDLE -> SEND:
  - Condition: in_valid & in_ready at edge T.
  - in_data is captured into the shift register; bit counter = DATA_W-1.
  - From T+1: p_x=1 and p_z=in_data[DATA_W-1].
- SEND, on an edge with p_y=1 (bit transfers):
  - Shift left; p_z shows the next bit; counter decrements.
- SEND, on an edge with p_y=0 (stall):
  - p_x, p_z and the counter hold unchanged; stalls have no length limit.
- Last bit (counter==0) transfers:
  - done=1 for the next cycle only.
  - p_x=0 and p_z=0 next cycle.
  - Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: p_x=0. Stay GAP_CYCLES cycles (counter reloaded), then IDLE.
- Latency with p_y tied high:
  - Accept edge to first bit visible: 1 cycle.
  - One frame occupies DATA_W cycles of p_x=1, then GAP_CYCLES, before in_ready returns.
  - Throughput is one word per DATA_W+GAP_CYCLES+1 cycles.
- in_valid while busy is ignored; in_data is not sampled outside accept edges.
- p_y is a don't-care whenever p_x=0.
- Counter width: clog2(DATA_W+1) bits. The counter must never wrap below 0.

Optional Feature:
- Macro: XYZ_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PAR instead of GAP/IDLE.
  - PAR drives p_x=1 and p_z = even parity (XOR of all DATA_W captured bits), with the same stall rule on p_y.
  - done pulses after the parity bit transfers, not after the last data bit.
  - A frame is DATA_W+1 bits.
- Undefined: no PAR state; behaviour exactly as above.

Test Plan:
- Reset release, in_valid=0, 5 cycles -> p_x=0, p_z=0, busy=0, done=0, in_ready=1 every cycle.
- DATA_W=8, GAP_CYCLES=1, p_y=1, send 0xA5 -> for 8 cycles p_x=1, p_z=1,0,1,0,0,1,0,1; done high on the cycle after bit 8; 1 gap cycle; in_ready=1 on cycle 10 after accept.
- Send 0x3C with p_y low on bits 2 and 5 for 3 cycles each -> p_z held during stalls, serial sequence still 0,0,1,1,1,1,0,0, frame spans 14 cycles, exactly one done.
- Back-to-back 0xFF then 0x00 with in_valid held high, GAP_CYCLES=0 -> the second word is accepted on the first IDLE cycle; p_x low for exactly one cycle between frames; in_valid asserted while busy is ignored.
- rst_n low for one edge at bit 4 of 0x81 -> next cycle p_x=0, no done, in_ready=1; a following 0x81 transmits 1,0,0,0,0,0,0,1 cleanly.
- XYZ_TX_PARITY_EN defined, send 0x07 -> 9 bits: 0,0,0,0,0,1,1,1, then 1; done after the 9th bit.
